rysy_fetch_arb: RTL and testbench

Parametrised instruction-prefetch and memory-port arbiter for the rysy core. It owns the core's single memory port (addr/wdata/we/be/rdata) and shares it between sequential instruction fetch and core-issued data accesses. Fetched words are buffered in a DEPTH-entry prefetch queue. Fetch is redirectable and flushable for jumps and taken branches. It sits between the control/decode logic and external memory, replacing the fixed PC/ALU address multiplexing with a generalised, buffered path.

---
 rtl/rysy_pkg.sv | 13 +
 rtl/rysy_fifo.sv | 78 +++++++
 rtl/rysy_fetch_arb.sv | 119 +++++++++++
 tb/tb_rysy_fetch_arb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rysy_pkg.sv
// Shared constants for the rysy core: register width, byte-enable patterns and
// instruction alignment.
package rysy_pkg;

    localparam int REG_LEN = 32;

    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    // Instructions are word aligned; this many low address bits are always zero.
    localparam int INST_ALIGN_BITS = 2;

endpackage

// File: rtl/rysy_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy output.
// DEPTH must be a power of two so the pointers wrap on their own.
module rysy_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [OW-1:0]    occ_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [OW-1:0]    occ_q;
    logic [OW-1:0]    occ_d;
    logic             do_push;
    logic             do_pop;

    assign valid_o = (occ_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && valid_o && !flush_i;

    // NOTE: a combinational block assigns every output a default first so no path can infer a latch.
    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else if (do_push && !do_pop) begin
            occ_d = occ_q + OW'(1);
        end else if (do_pop && !do_push) begin
            occ_d = occ_q - OW'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; only pointers and occupancy are, and nothing reads an empty slot.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            occ_q <= occ_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // The fetch throttle guarantees a free slot for every response it expects.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            assert (occ_q != OW'(DEPTH));
        end
    end

endmodule

// File: rtl/rysy_fetch_arb.sv
// Instruction prefetch and memory-port arbiter: data accesses win the single
// memory port, sequential fetch fills a prefetch queue whenever it can.
module rysy_fetch_arb
    import rysy_pkg::*;
#(
    parameter int             XLEN     = REG_LEN,
    parameter int             DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            dreq,
    input  logic            dwe,
    input  logic [3:0]      dbe,
    input  logic [XLEN-1:0] daddr,
    input  logic [XLEN-1:0] dwdata,
    output logic            dgnt,
    output logic            drvalid,
    output logic [XLEN-1:0] drdata,
    output logic [XLEN-1:0] addr,
    output logic            we,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata
);

    localparam int              OW         = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << INST_ALIGN_BITS;

    logic [XLEN-1:0]   fetch_pc_q;
    logic [XLEN-1:0]   fetch_pc_d;
    logic [XLEN-1:0]   infl_pc_q;
    logic              infl_q;
    logic              drop_q;
    logic              dresp_q;
    logic              data_gnt;
    logic              fetch_go;
    logic              push;
    logic [OW-1:0]     occ;
    logic [OW:0]       pending;
    logic [2*XLEN-1:0] head;
    logic              head_valid;

    assign data_gnt = dreq && !rst;
    assign pending  = {1'b0, occ} + {{OW{1'b0}}, infl_q};
    // Counting the outstanding fetch reserves a queue slot for its response.
    assign fetch_go = !rst && !dreq && (pending < (OW+1)'(DEPTH));
    assign push     = infl_q && !drop_q && !redirect && !rst;

    rysy_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (push),
        .data_i  ({infl_pc_q, rdata}),
        .pop_i   (inst_ready),
        .head_o  (head),
        .valid_o (head_valid),
        .occ_o   (occ)
    );

    always_comb begin
        addr  = fetch_pc_q;
        we    = 1'b0;
        be    = BE_NONE;
        wdata = '0;
        if (data_gnt) begin
            addr  = daddr;
            we    = dwe;
            be    = dbe;
            wdata = dwdata;
        end else if (fetch_go) begin
            be = BE_FULL;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ALIGN_MASK;
        end else if (fetch_go) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            infl_pc_q  <= '0;
            infl_q     <= 1'b0;
            drop_q     <= 1'b0;
            dresp_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            infl_q     <= fetch_go;
            // A fetch issued alongside a redirect fetched the old stream.
            drop_q     <= fetch_go && redirect;
            dresp_q    <= data_gnt && !dwe;
            if (fetch_go) infl_pc_q <= fetch_pc_q;
        end
    end

    assign dgnt       = data_gnt;
    assign drvalid    = dresp_q;
    assign drdata     = dresp_q ? rdata : '0;
    assign inst_valid = head_valid;
    assign inst       = head_valid ? head[XLEN-1:0] : '0;
    assign inst_pc    = head_valid ? head[2*XLEN-1:XLEN] : '0;

endmodule

// File: tb/tb_rysy_fetch_arb.sv
// Directed bench for rysy_fetch_arb: a vector table for streaming, data access
// and redirect, plus hand-written stall, redirect+write and mid-run reset cases.
module tb_rysy_fetch_arb;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        dgnt;
    logic        drvalid;
    logic [31:0] drdata;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_pass   = 0;

    rysy_fetch_arb #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .dreq        (dreq),
        .dwe         (dwe),
        .dbe         (dbe),
        .daddr       (daddr),
        .dwdata      (dwdata),
        .dgnt        (dgnt),
        .drvalid     (drvalid),
        .drdata      (drdata),
        .addr        (addr),
        .we          (we),
        .be          (be),
        .wdata       (wdata),
        .rdata       (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: unwritten words read back as their own address.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a;
    endfunction

    always @(posedge clk) begin
        logic [31:0] w;
        if (we) begin
            w = mem_rd(addr);
            for (int b = 0; b < 4; b++) begin
                if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            end
            mem[addr] = w;
        end
        rdata <= (!we && be != 4'b0000) ? mem_rd(addr) : 32'h0BAD_0BAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ctrl = {redirect, dreq, dwe, inst_ready}; applied just after the falling edge.
    task automatic drive(input logic rs, input logic [3:0] ctrl, input logic [31:0] rpc,
                         input logic [3:0] b, input logic [31:0] da, input logic [31:0] dwd);
        @(negedge clk);
        rst         = rs;
        redirect    = ctrl[3];
        dreq        = ctrl[2];
        dwe         = ctrl[1];
        inst_ready  = ctrl[0];
        redirect_pc = rpc;
        dbe         = b;
        daddr       = da;
        dwdata      = dwd;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0101, 32'h0, 4'hF, 32'h100, 32'h0);
        drive(1'b1, 4'b0101, 32'h0, 4'hF, 32'h100, 32'h0);
        check("rst dgnt",       {31'b0, dgnt},       32'h0);
        check("rst we",         {31'b0, we},         32'h0);
        check("rst be",         {28'b0, be},         32'h0);
        check("rst addr",       addr,                RESET_PC);
        check("rst inst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst inst",       inst,                32'h0);
        check("rst inst_pc",    inst_pc,             32'h0);
        check("rst drvalid",    {31'b0, drvalid},    32'h0);
        check("rst drdata",     drdata,              32'h0);
    endtask

    // ef = {we, dgnt, inst_valid, drvalid}
    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] rpc;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [3:0]  ef;
        logic [31:0] e_wdata;
        logic [31:0] e_pc;
        logic [31:0] e_drdata;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] ctrl, input logic [31:0] rpc, input logic [3:0] b,
                                input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] ea,
                                input logic [3:0] eb, input logic [3:0] ef, input logic [31:0] ewd,
                                input logic [31:0] epc, input logic [31:0] edr);
        vec_t v;
        v.ctrl = ctrl; v.rpc = rpc; v.dbe = b; v.daddr = da; v.dwdata = dwd;
        v.e_addr = ea; v.e_be = eb; v.ef = ef; v.e_wdata = ewd; v.e_pc = epc; v.e_drdata = edr;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        dreq = 1'b0; dwe = 1'b0; dbe = '0; daddr = '0; dwdata = '0;
        mem[32'h100] = 32'hCAFE_F00D;

        //                ctrl     rpc       dbe   daddr     dwdata        e_addr    e_be  ef       e_wdata       e_pc      e_drdata
        vecs[0]  = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h00,  4'hF, 4'b0000, 32'h0,        32'h00, 32'h0);
        vecs[1]  = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h04,  4'hF, 4'b0000, 32'h0,        32'h00, 32'h0);
        vecs[2]  = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h08,  4'hF, 4'b0010, 32'h0,        32'h00, 32'h0);
        vecs[3]  = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h0C,  4'hF, 4'b0010, 32'h0,        32'h04, 32'h0);
        vecs[4]  = mk(4'b0101, 32'h0,  4'hF, 32'h100, 32'h0,        32'h100, 4'hF, 4'b0110, 32'h0,        32'h08, 32'h0);
        vecs[5]  = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h10,  4'hF, 4'b0011, 32'h0,        32'h0C, 32'hCAFE_F00D);
        vecs[6]  = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h14,  4'hF, 4'b0000, 32'h0,        32'h00, 32'h0);
        vecs[7]  = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h18,  4'hF, 4'b0010, 32'h0,        32'h10, 32'h0);
        vecs[8]  = mk(4'b1001, 32'h43, 4'h0, 32'h0,   32'h0,        32'h1C,  4'hF, 4'b0010, 32'h0,        32'h14, 32'h0);
        vecs[9]  = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h40,  4'hF, 4'b0000, 32'h0,        32'h00, 32'h0);
        vecs[10] = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h44,  4'hF, 4'b0000, 32'h0,        32'h00, 32'h0);
        vecs[11] = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h48,  4'hF, 4'b0010, 32'h0,        32'h40, 32'h0);
        vecs[12] = mk(4'b0111, 32'h0,  4'h3, 32'h300, 32'hDEAD_BEEF, 32'h300, 4'h3, 4'b1110, 32'hDEAD_BEEF, 32'h44, 32'h0);
        vecs[13] = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h4C,  4'hF, 4'b0010, 32'h0,        32'h48, 32'h0);
        vecs[14] = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h50,  4'hF, 4'b0000, 32'h0,        32'h00, 32'h0);
        vecs[15] = mk(4'b0001, 32'h0,  4'h0, 32'h0,   32'h0,        32'h54,  4'hF, 4'b0010, 32'h0,        32'h4C, 32'h0);

        // Streaming, data read, redirect and data write.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, vecs[i].ctrl, vecs[i].rpc, vecs[i].dbe, vecs[i].daddr, vecs[i].dwdata);
            check($sformatf("v%0d addr", i),       addr,                  vecs[i].e_addr);
            check($sformatf("v%0d be", i),         {28'b0, be},           {28'b0, vecs[i].e_be});
            check($sformatf("v%0d we", i),         {31'b0, we},           {31'b0, vecs[i].ef[3]});
            check($sformatf("v%0d wdata", i),      wdata,                 vecs[i].e_wdata);
            check($sformatf("v%0d dgnt", i),       {31'b0, dgnt},         {31'b0, vecs[i].ef[2]});
            check($sformatf("v%0d inst_valid", i), {31'b0, inst_valid},   {31'b0, vecs[i].ef[1]});
            check($sformatf("v%0d inst_pc", i),    inst_pc,               vecs[i].e_pc);
            check($sformatf("v%0d inst", i),       inst,                  vecs[i].e_pc);
            check($sformatf("v%0d drvalid", i),    {31'b0, drvalid},      {31'b0, vecs[i].ef[0]});
            check($sformatf("v%0d drdata", i),     drdata,                vecs[i].e_drdata);
        end

        // Consumer stalled: four fetches fill the queue, then the port idles at 16.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0);
            check($sformatf("stall fetch%0d addr", i), addr, 32'(4 * i));
            check($sformatf("stall fetch%0d be", i), {28'b0, be}, 32'hF);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0);
            check($sformatf("stall idle%0d addr", i), addr, 32'h10);
            check($sformatf("stall idle%0d be", i), {28'b0, be}, 32'h0);
        end
        check("stall head pc", inst_pc, 32'h0);
        drive(1'b0, 4'b0001, 32'h0, 4'h0, 32'h0, 32'h0);
        check("stall pop be", {28'b0, be}, 32'h0);
        check("stall pop valid", {31'b0, inst_valid}, 32'h1);
        drive(1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0);
        check("stall refill addr", addr, 32'h10);
        check("stall refill be", {28'b0, be}, 32'hF);
        check("stall refill head", inst_pc, 32'h4);
        drive(1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0);
        check("stall full again addr", addr, 32'h14);
        check("stall full again be", {28'b0, be}, 32'h0);

        // Redirect and data write in the same cycle.
        do_reset();
        drive(1'b0, 4'b0001, 32'h0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 4'b0001, 32'h0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 4'b1111, 32'h80, 4'h3, 32'h200, 32'hDEAD_BEEF);
        check("rdw dgnt", {31'b0, dgnt}, 32'h1);
        check("rdw addr", addr, 32'h200);
        check("rdw we", {31'b0, we}, 32'h1);
        check("rdw be", {28'b0, be}, 32'h3);
        check("rdw wdata", wdata, 32'hDEAD_BEEF);
        drive(1'b0, 4'b0001, 32'h0, 4'h0, 32'h0, 32'h0);
        check("rdw fetch addr", addr, 32'h80);
        check("rdw fetch be", {28'b0, be}, 32'hF);
        check("rdw fetch we", {31'b0, we}, 32'h0);
        check("rdw flushed", {31'b0, inst_valid}, 32'h0);
        drive(1'b0, 4'b0001, 32'h0, 4'h0, 32'h0, 32'h0);
        check("rdw second addr", addr, 32'h84);
        check("rdw still empty", {31'b0, inst_valid}, 32'h0);
        drive(1'b0, 4'b0001, 32'h0, 4'h0, 32'h0, 32'h0);
        check("rdw first valid", {31'b0, inst_valid}, 32'h1);
        check("rdw first pc", inst_pc, 32'h80);
        check("rdw first inst", inst, 32'h80);
        drive(1'b0, 4'b0101, 32'h0, 4'hF, 32'h200, 32'h0);
        drive(1'b0, 4'b0001, 32'h0, 4'h0, 32'h0, 32'h0);
        check("rdw readback valid", {31'b0, drvalid}, 32'h1);
        check("rdw readback data", drdata, 32'h0000_BEEF);

        // Reset with three queued entries and a fetch in flight.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0);
        end
        check("mrst last fetch", addr, 32'hC);
        drive(1'b1, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0);
        check("mrst be in reset", {28'b0, be}, 32'h0);
        drive(1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0);
        check("mrst valid", {31'b0, inst_valid}, 32'h0);
        check("mrst addr", addr, RESET_PC);
        check("mrst be", {28'b0, be}, 32'hF);
        drive(1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0);
        check("mrst no stale push", {31'b0, inst_valid}, 32'h0);
        drive(1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0);
        check("mrst refetch valid", {31'b0, inst_valid}, 32'h1);
        check("mrst refetch pc", inst_pc, RESET_PC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
